// File: rtl/paddle_ctrl.sv
// Paddle controller: vertical movement with clamping plus a timed horizontal smash lunge.
// One instance per side; all outputs are registered.
module paddle_ctrl #(
  parameter int unsigned W          = 10,
  parameter int unsigned X_HOME     = 0,
  parameter int unsigned Y_INIT     = 0,
  parameter int unsigned Y_MIN      = 0,
  parameter int unsigned Y_MAX      = 10,
  parameter int unsigned STEP       = 1,
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned DIR        = 0,
  parameter int unsigned SMASH_DX   = 8,
  parameter int unsigned LUNGE_STEP = 2,
  parameter int unsigned HOLD_TICKS = 4,
  parameter int unsigned COOL_TICKS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         up,
  input  logic         down,
  input  logic         smash,
  output logic [W-1:0] x_barra,
  output logic [W-1:0] y_barra,
  output logic         smash_active,
  output logic         busy
);

  localparam int unsigned PW      = W + 1;
  localparam int unsigned TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_MAX = (HOLD_TICKS > COOL_TICKS) ? HOLD_TICKS : COOL_TICKS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_OUT, S_HOLD, S_RET, S_COOL} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   off_q, off_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic            smash_q, smash_d;
  logic            pend_q, pend_d;
  logic            smash_active_q, smash_active_d;
  logic            busy_q, busy_d;

  logic            tick_c;
  logic            req_c;
  logic [PW-1:0]   y_ext_c;
  logic [PW-1:0]   y_nxt_c;
  logic [PW-1:0]   off_sum_c;

  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    cnt_d          = cnt_q;
    off_d          = off_q;
    y_d            = y_q;
    smash_d        = smash_q;
    pend_d         = pend_q;
    y_ext_c        = {1'b0, y_q};
    y_nxt_c        = y_ext_c;
    off_sum_c      = off_q + PW'(LUNGE_STEP);
    tick_c         = enable && (tick_cnt_q == TW'(TICK_DIV - 1));
    req_c          = enable && smash && !smash_q;

    if (enable) begin
      smash_d    = smash;
      tick_cnt_d = tick_c ? '0 : tick_cnt_q + TW'(1);
      pend_d     = tick_c ? 1'b0 : (pend_q | req_c);
    end

    if (tick_c) begin
      // Vertical motion in W+1 bits, then clamp into [Y_MIN, Y_MAX]
      if (up && !down) begin
        y_nxt_c = (y_ext_c >= PW'(STEP)) ? y_ext_c - PW'(STEP) : '0;
      end else if (down && !up) begin
        y_nxt_c = y_ext_c + PW'(STEP);
      end
      if (y_nxt_c < PW'(Y_MIN)) y_nxt_c = PW'(Y_MIN);
      if (y_nxt_c > PW'(Y_MAX)) y_nxt_c = PW'(Y_MAX);
      y_d = W'(y_nxt_c);

      unique case (state_q)
        S_IDLE: if (pend_q || req_c) state_d = S_OUT;
        S_OUT: begin
          off_d = (off_sum_c >= PW'(SMASH_DX)) ? PW'(SMASH_DX) : off_sum_c;
          if (off_d == PW'(SMASH_DX)) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        end
        S_HOLD: begin
          if (32'(cnt_q) + 32'd1 >= HOLD_TICKS) state_d = S_RET;
          else                                  cnt_d   = cnt_q + CW'(1);
        end
        S_RET: begin
          off_d = (off_q >= PW'(LUNGE_STEP)) ? off_q - PW'(LUNGE_STEP) : '0;
          if (off_d == '0) begin
            state_d = S_COOL;
            cnt_d   = '0;
          end
        end
        S_COOL: begin
          if (32'(cnt_q) + 32'd1 >= COOL_TICKS) state_d = S_IDLE;
          else                                  cnt_d   = cnt_q + CW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end

    x_d            = (DIR != 0) ? W'(X_HOME) - W'(off_d) : W'(X_HOME) + W'(off_d);
    smash_active_d = (state_d == S_OUT) || (state_d == S_HOLD);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      tick_cnt_q     <= '0;
      cnt_q          <= '0;
      off_q          <= '0;
      x_q            <= W'(X_HOME);
      y_q            <= W'(Y_INIT);
      smash_q        <= 1'b0;
      pend_q         <= 1'b0;
      smash_active_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      cnt_q          <= cnt_d;
      off_q          <= off_d;
      x_q            <= x_d;
      y_q            <= y_d;
      smash_q        <= smash_d;
      pend_q         <= pend_d;
      smash_active_q <= smash_active_d;
      busy_q         <= busy_d;
    end
  end

  assign x_barra      = x_q;
  assign y_barra      = y_q;
  assign smash_active = smash_active_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: three instances (defaults, fast/coarse y, right-side lunge).
module tb_paddle_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en0, up0, down0, smash0;
  logic en1, up1, down1, smash1;
  logic en2, up2, down2, smash2;
  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic sa0, b0, sa1, b1, sa2, b2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  paddle_ctrl u0 (
    .clk(clk), .reset(reset), .enable(en0), .up(up0), .down(down0), .smash(smash0),
    .x_barra(x0), .y_barra(y0), .smash_active(sa0), .busy(b0)
  );

  paddle_ctrl #(.TICK_DIV(4), .STEP(3), .Y_MAX(10)) u1 (
    .clk(clk), .reset(reset), .enable(en1), .up(up1), .down(down1), .smash(smash1),
    .x_barra(x1), .y_barra(y1), .smash_active(sa1), .busy(b1)
  );

  paddle_ctrl #(.DIR(1), .X_HOME(600), .Y_INIT(5)) u2 (
    .clk(clk), .reset(reset), .enable(en2), .up(up2), .down(down2), .smash(smash2),
    .x_barra(x2), .y_barra(y2), .smash_active(sa2), .busy(b2)
  );

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected lunge offset k cycles after the edge that accepted the request (default params)
  function automatic int lunge_off(input int k);
    if (k <= 1)  return 0;
    if (k <= 5)  return 2 * (k - 1);
    if (k <= 9)  return 8;
    if (k <= 13) return 8 - 2 * (k - 9);
    return 0;
  endfunction

  initial begin
    {en0, up0, down0, smash0} = 4'b0000;
    {en1, up1, down1, smash1} = 4'b0000;
    {en2, up2, down2, smash2} = 4'b1000;

    // Reset held for three cycles
    step(3);
    chk("rst_x0", 0, 32'(x0), 0);
    chk("rst_y0", 0, 32'(y0), 0);
    chk("rst_busy0", 0, 32'(b0), 0);
    chk("rst_sa0", 0, 32'(sa0), 0);
    chk("rst_x2", 0, 32'(x2), 600);
    chk("rst_y2", 0, 32'(y2), 5);

    // Down held: y climbs to Y_MAX and stays
    reset = 1'b1; en0 = 1'b1; down0 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step(1);
      chk("down_y0", k, 32'(y0), (k < 10) ? k : 10);
    end
    // Up held: y falls to Y_MIN and stays
    down0 = 1'b0; up0 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("up_y0", k, 32'(y0), (k < 10) ? 10 - k : 0);
    end
    up0 = 1'b0;

    // TICK_DIV=4, STEP=3: moves every fourth cycle, clamps at 10
    en1 = 1'b1; down1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk("div_y1", k, 32'(y1), ((3 * (k / 4)) < 10) ? 3 * (k / 4) : 10);
    end
    down1 = 1'b0;

    // Single-cycle smash pulse: full lunge timeline
    smash0 = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step(1);
      chk("lunge_x0", k, 32'(x0), lunge_off(k));
      chk("lunge_sa0", k, 32'(sa0), (k <= 8) ? 1 : 0);
      chk("lunge_busy0", k, 32'(b0), (k <= 28) ? 1 : 0);
      if (k == 1) smash0 = 1'b0;
    end

    // Smash held high with a fresh edge during COOL: exactly one lunge
    smash0 = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step(1);
      chk("hold_x0", k, 32'(x0), lunge_off(k));
      chk("hold_busy0", k, 32'(b0), (k <= 28) ? 1 : 0);
      if (k == 15) smash0 = 1'b0;
      if (k == 17) smash0 = 1'b1;
    end
    smash0 = 1'b0;

    // Right-side paddle lunges toward -x; up+down together hold y
    up2 = 1'b1; down2 = 1'b1; smash2 = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step(1);
      chk("dir_x2", k, 32'(x2), 600 - lunge_off(k));
      chk("dir_y2", k, 32'(y2), 5);
      if (k == 1) smash2 = 1'b0;
    end
    up2 = 1'b0; down2 = 1'b0;

    // Async reset while in HOLD
    down0 = 1'b1;
    step(3);
    chk("pre_y0", 0, 32'(y0), 3);
    down0 = 1'b0; smash0 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (k == 1) smash0 = 1'b0;
    end
    chk("hold_x8", 6, 32'(x0), 8);
    chk("hold_sa", 6, 32'(sa0), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_x0", 0, 32'(x0), 0);
    chk("arst_y0", 0, 32'(y0), 0);
    chk("arst_busy0", 0, 32'(b0), 0);
    chk("arst_sa0", 0, 32'(sa0), 0);
    step(2);
    reset = 1'b1;

    // Freeze mid-OUT: nothing moves, then resumes in place
    smash0 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      if (k == 1) smash0 = 1'b0;
    end
    chk("frz_pre_x0", 3, 32'(x0), 4);
    en0 = 1'b0; down0 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("frz_x0", k, 32'(x0), 4);
      chk("frz_y0", k, 32'(y0), 0);
      chk("frz_sa0", k, 32'(sa0), 1);
    end
    en0 = 1'b1; down0 = 1'b0;
    step(1);
    chk("resume_x0", 1, 32'(x0), 6);
    step(1);
    chk("resume_x0", 2, 32'(x0), 8);
    chk("resume_sa0", 2, 32'(sa0), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
